nv_ram_rwsp_wm: RTL and testbench

NV_RAM_RWSP_WM -- requirements
Module: nv_ram_rwsp_wm

---
 rtl/nv_ram_rwsp_wm.sv | 134 +++++++++++++
 tb/tb_nv_ram_rwsp_wm.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/nv_ram_rwsp_wm.sv
// Single-port-per-direction RAM (one read, one write port) with per-byte write mask,
// a self-clearing INIT sweep after reset and an optional extra output register.
module nv_ram_rwsp_wm #(
    parameter int DW      = 8,
    parameter int AW      = 8,
    parameter int OUT_REG = 0
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [AW-1:0] ra,
    input  logic          re,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    input  logic [AW-1:0] wa,
    input  logic          we,
    input  logic [DW-1:0] di,
    input  logic [DW/8-1:0] wmask,
    output logic          init_done,
    input  logic [31:0]   pwrbus_ram_pd
);

    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    typedef enum logic {INIT, IDLE} state_t;

    state_t        state;
    logic [AW-1:0] cnt;
    logic          init_done_q;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] fwd_data;
    logic [DW-1:0] rd_data;
    logic          rd_vld;
    logic          clr_en;
    logic          wr_en;
    logic          rd_en;
    logic          unused_pwrbus;

    assign unused_pwrbus = ^pwrbus_ram_pd;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= INIT;
            cnt         <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state       <= IDLE;
                        init_done_q <= 1'b1;
                    end
                end
                IDLE: begin
                    init_done_q <= 1'b1;
                end
                default: begin
                    state       <= INIT;
                    cnt         <= '0;
                    init_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign init_done = init_done_q;
    assign clr_en    = rstn && (state == INIT);
    assign wr_en     = rstn && (state == IDLE) && we;
    assign rd_en     = (state == IDLE) && re;

    // The array itself is never reset; only the INIT sweep zeroes it.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[cnt] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wmask[i]) begin
                    mem[wa][8*i +: 8] <= di[8*i +: 8];
                end
            end
        end
    end

    // Same-cycle write to the read address is forwarded lane by lane.
    always_comb begin
        fwd_data = mem[ra];
        if (we && (wa == ra)) begin
            for (int i = 0; i < NB; i++) begin
                if (wmask[i]) begin
                    fwd_data[8*i +: 8] = di[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_data <= '0;
            rd_vld  <= 1'b0;
        end else begin
            rd_vld <= rd_en;
            if (rd_en) begin
                rd_data <= fwd_data;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DW-1:0] out_data;
            logic          out_vld;

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    out_data <= '0;
                    out_vld  <= 1'b0;
                end else begin
                    out_vld <= rd_vld;
                    if (rd_vld) begin
                        out_data <= rd_data;
                    end
                end
            end

            assign dout     = out_data;
            assign dout_vld = out_vld;
        end else begin : g_no_out_reg
            assign dout     = rd_data;
            assign dout_vld = rd_vld;
        end
    endgenerate

endmodule

// File: tb/tb_nv_ram_rwsp_wm.sv
// Directed bench for nv_ram_rwsp_wm: two instances (latency 1 and latency 2)
// share one stimulus stream and are checked against hand-computed values.
module tb_nv_ram_rwsp_wm;

    logic        clk;
    logic        rstn;
    logic [3:0]  ra;
    logic        re;
    logic [3:0]  wa;
    logic        we;
    logic [31:0] di;
    logic [3:0]  wmask;
    logic [31:0] pwrbus_ram_pd;

    logic [31:0] dout0, dout1;
    logic        vld0, vld1;
    logic        done0, done1;

    int tests_run;
    int fail_count;

    nv_ram_rwsp_wm #(.DW(32), .AW(4), .OUT_REG(0)) u_lat1 (
        .clk(clk), .rstn(rstn), .ra(ra), .re(re), .dout(dout0), .dout_vld(vld0),
        .wa(wa), .we(we), .di(di), .wmask(wmask), .init_done(done0),
        .pwrbus_ram_pd(pwrbus_ram_pd)
    );

    nv_ram_rwsp_wm #(.DW(32), .AW(4), .OUT_REG(1)) u_lat2 (
        .clk(clk), .rstn(rstn), .ra(ra), .re(re), .dout(dout1), .dout_vld(vld1),
        .wa(wa), .we(we), .di(di), .wmask(wmask), .init_done(done1),
        .pwrbus_ram_pd(pwrbus_ram_pd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled and inputs changed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        tests_run     = 0;
        fail_count    = 0;
        rstn          = 1'b0;
        re            = 1'b0;
        we            = 1'b0;
        ra            = '0;
        wa            = '0;
        di            = '0;
        wmask         = '0;
        pwrbus_ram_pd = 32'hDEAD_BEEF;

        step();
        step();
        checkOutput("reset_done0", 32'(done0), 32'd0);
        checkOutput("reset_done1", 32'(done1), 32'd0);
        checkOutput("reset_vld0",  32'(vld0),  32'd0);
        checkOutput("reset_vld1",  32'(vld1),  32'd0);
        checkOutput("reset_dout0", dout0, 32'd0);
        checkOutput("reset_dout1", dout1, 32'd0);

        // Release reset while hammering re/we: INIT must ignore both
        rstn  = 1'b1;
        re    = 1'b1;
        we    = 1'b1;
        ra    = 4'd5;
        wa    = 4'd5;
        di    = 32'hFFFF_FFFF;
        wmask = 4'hF;
        for (int k = 1; k <= 16; k++) begin
            step();
            checkOutput("init_vld0", 32'(vld0), 32'd0);
            checkOutput("init_vld1", 32'(vld1), 32'd0);
            if (k == 15) begin
                checkOutput("init_done0_early", 32'(done0), 32'd0);
                checkOutput("init_done1_early", 32'(done1), 32'd0);
            end
        end
        checkOutput("init_done0", 32'(done0), 32'd1);
        checkOutput("init_done1", 32'(done1), 32'd1);
        re = 1'b0;
        we = 1'b0;

        // Back-to-back read of every address after the clear
        for (int i = 0; i < 16; i++) begin
            ra = 4'(i);
            re = 1'b1;
            step();
            checkOutput("sweep_vld0",  32'(vld0), 32'd1);
            checkOutput("sweep_dout0", dout0, 32'd0);
            if (i > 0) begin
                checkOutput("sweep_vld1",  32'(vld1), 32'd1);
                checkOutput("sweep_dout1", dout1, 32'd0);
            end
        end
        re = 1'b0;
        step();
        checkOutput("sweep_end_vld0", 32'(vld0), 32'd0);
        checkOutput("sweep_end_vld1", 32'(vld1), 32'd1);
        step();
        checkOutput("sweep_end2_vld1", 32'(vld1), 32'd0);

        // Byte-masked merge on address 3
        we = 1'b1; wa = 4'd3; di = 32'h1122_3344; wmask = 4'hF;
        step();
        di = 32'hAABB_CCDD; wmask = 4'h5;
        step();
        we = 1'b0; ra = 4'd3; re = 1'b1;
        step();
        checkOutput("mask_vld0",  32'(vld0), 32'd1);
        checkOutput("mask_dout0", dout0, 32'h11BB_33DD);
        checkOutput("mask_vld1_early", 32'(vld1), 32'd0);
        re = 1'b0;
        step();
        checkOutput("mask_vld0_drop", 32'(vld0), 32'd0);
        checkOutput("mask_dout0_hold", dout0, 32'h11BB_33DD);
        checkOutput("mask_vld1",  32'(vld1), 32'd1);
        checkOutput("mask_dout1", dout1, 32'h11BB_33DD);
        step();
        checkOutput("mask_vld1_drop", 32'(vld1), 32'd0);

        // we with an all-zero mask leaves the entry untouched
        we = 1'b1; wa = 4'd3; di = 32'h0000_0000; wmask = 4'h0;
        step();
        we = 1'b0; ra = 4'd3; re = 1'b1;
        step();
        checkOutput("nomask_dout0", dout0, 32'h11BB_33DD);
        re = 1'b0;
        step();

        // Same-cycle read/write collision on address 7 with lane 1 only
        re = 1'b1; ra = 4'd7; we = 1'b1; wa = 4'd7; di = 32'hFFFF_FFFF; wmask = 4'h2;
        step();
        checkOutput("fwd_vld0",  32'(vld0), 32'd1);
        checkOutput("fwd_dout0", dout0, 32'h0000_FF00);
        we = 1'b0;
        step();
        checkOutput("fwd_reread_dout0", dout0, 32'h0000_FF00);
        checkOutput("fwd_dout1", dout1, 32'h0000_FF00);
        re = 1'b0;
        step();
        checkOutput("fwd_reread_dout1", dout1, 32'h0000_FF00);

        // Write then read the next cycle returns new data
        we = 1'b1; wa = 4'd9; di = 32'h1234_5678; wmask = 4'hF;
        step();
        we = 1'b0; re = 1'b1; ra = 4'd9;
        step();
        checkOutput("raw_dout0", dout0, 32'h1234_5678);
        re = 1'b0;
        step();

        // Pipelined reads of 0xA0..0xA3
        for (int i = 0; i < 4; i++) begin
            we = 1'b1; wa = 4'(i); di = 32'hA0 + 32'(i); wmask = 4'hF;
            step();
        end
        we = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            ra = 4'(i);
            re = 1'b1;
            step();
            checkOutput("pipe_vld0",  32'(vld0), 32'd1);
            checkOutput("pipe_dout0", dout0, 32'hA0 + 32'(i));
            if (i == 0) begin
                checkOutput("pipe_vld1_first", 32'(vld1), 32'd0);
            end else begin
                checkOutput("pipe_vld1",  32'(vld1), 32'd1);
                checkOutput("pipe_dout1", dout1, 32'hA0 + 32'(i - 1));
            end
        end
        re = 1'b0;
        step();
        checkOutput("pipe_vld0_end", 32'(vld0), 32'd0);
        checkOutput("pipe_vld1_last", 32'(vld1), 32'd1);
        checkOutput("pipe_dout1_last", dout1, 32'h0000_00A3);
        step();
        checkOutput("pipe_vld1_end", 32'(vld1), 32'd0);
        checkOutput("pipe_dout1_hold", dout1, 32'h0000_00A3);

        // Reset one cycle after a read: in-flight data is discarded and INIT restarts
        re = 1'b1; ra = 4'd9;
        step();
        re = 1'b0;
        rstn = 1'b0;
        step();
        checkOutput("rst_vld0",  32'(vld0),  32'd0);
        checkOutput("rst_dout0", dout0, 32'd0);
        checkOutput("rst_vld1",  32'(vld1),  32'd0);
        checkOutput("rst_dout1", dout1, 32'd0);
        checkOutput("rst_done0", 32'(done0), 32'd0);
        rstn = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            checkOutput("rerun_vld0", 32'(vld0), 32'd0);
            checkOutput("rerun_vld1", 32'(vld1), 32'd0);
            if (k == 15) begin
                checkOutput("rerun_done0_early", 32'(done0), 32'd0);
            end
        end
        checkOutput("rerun_done0", 32'(done0), 32'd1);
        checkOutput("rerun_done1", 32'(done1), 32'd1);

        re = 1'b1; ra = 4'd9;
        step();
        checkOutput("rerun_clear9_dout0", dout0, 32'd0);
        ra = 4'd0;
        step();
        checkOutput("rerun_clear0_dout0", dout0, 32'd0);
        checkOutput("rerun_clear9_dout1", dout1, 32'd0);
        re = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
